// File: rtl/da_dct_stage.sv
// Distributed-arithmetic DCT half-stage: loads an NPTS-sample frame, forms the even or odd butterfly, then
// produces NCOEF inner products bit-serially from an external partial-sum ROM. Define DA_DCT_SCALE_EN to round away the ROM Q(CW-1) scale.
module da_dct_stage #(
    parameter int NPTS  = 16,
    parameter int DW    = 15,
    parameter int CW    = 15,
    parameter int NCOEF = 8,
    localparam int H    = NPTS / 2,
    localparam int BW   = DW + 1,
    localparam int OW   = CW + BW,
    localparam int KW   = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 mode,
    output logic [H-1:0]         rom_slice,
    output logic [KW-1:0]        rom_k,
    input  logic signed [CW-1:0] rom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic [KW-1:0]        out_k,
    output logic                 out_last,
    output logic                 busy,
    output logic [2:0]           dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // the producer holds valid and data stable until that edge, ready never depends on the
    // same-cycle valid.
    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_BFLY = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;

    localparam int IW  = $clog2(NPTS);
    localparam int BCW = $clog2(BW);
    localparam logic [IW-1:0]  I_LAST = IW'(NPTS - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(BW - 1);
    localparam logic [KW-1:0]  K_LAST = KW'(NCOEF - 1);

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        i_q, i_d;
    logic [BCW-1:0]       b_q, b_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic signed [OW-1:0] out_data_q, out_data_d;
    logic                 mode_q, mode_d;
    logic                 rdy_q, rdy_d;
    logic signed [DW-1:0] buf_q [NPTS];
    logic signed [DW-1:0] buf_d [NPTS];
    logic signed [BW-1:0] x_q [H];
    logic signed [BW-1:0] x_d [H];

    logic signed [OW-1:0] term_c;
    logic signed [OW-1:0] term_sh_c;
    logic signed [OW-1:0] result_c;

    assign term_c    = OW'(rom_data);
    assign term_sh_c = term_c << b_q;

`ifdef DA_DCT_SCALE_EN
    logic signed [OW-1:0] rnd_c;
    logic signed [OW-1:0] rnd_sum_c;
    assign rnd_c     = OW'(1) << (CW - 2);
    assign rnd_sum_c = acc_q + rnd_c;
    assign result_c  = rnd_sum_c >>> (CW - 1);
`else
    assign result_c  = acc_q;
`endif

    // rdy_q holds in_ready low for the first cycle out of reset.
    assign rdy_d = 1'b1;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        b_d        = b_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        mode_d     = mode_q;
        buf_d      = buf_q;
        x_d        = x_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    buf_d[i_q] = in_data;
                    if (i_q == '0) mode_d = mode;
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = S_BFLY;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            S_BFLY: begin
                for (int m = 0; m < H; m++) begin
                    x_d[m] = mode_q ? (BW'(buf_q[m]) + BW'(buf_q[NPTS-1-m]))
                                    : (BW'(buf_q[m]) - BW'(buf_q[NPTS-1-m]));
                end
                acc_d   = '0;
                b_d     = '0;
                k_d     = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                // The MSB slice carries negative weight in two's complement.
                if (b_q == B_LAST) begin
                    acc_d   = acc_q - term_sh_c;
                    state_d = S_FIN;
                end else begin
                    acc_d = acc_q + term_sh_c;
                    b_d   = b_q + 1'b1;
                end
            end
            S_FIN: begin
                out_data_d = result_c;
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = S_LOAD;
                    end else begin
                        k_d     = k_q + 1'b1;
                        acc_d   = '0;
                        b_d     = '0;
                        state_d = S_ACC;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            i_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            mode_q     <= 1'b0;
            rdy_q      <= 1'b0;
            for (int n = 0; n < NPTS; n++) buf_q[n] <= '0;
            for (int m = 0; m < H; m++) x_q[m] <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            b_q        <= b_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            mode_q     <= mode_d;
            rdy_q      <= rdy_d;
            buf_q      <= buf_d;
            x_q        <= x_d;
        end
    end

    // x0 occupies the MSB of the ROM address.
    always_comb begin
        rom_slice = '0;
        if (state_q == S_ACC) begin
            for (int m = 0; m < H; m++) rom_slice[H-1-m] = x_q[m][b_q];
        end
    end

    assign rom_k     = (state_q == S_ACC) ? k_q : '0;
    assign in_ready  = (state_q == S_LOAD) && rdy_q;
    assign out_valid = (state_q == S_EMIT);
    assign out_data  = out_data_q;
    assign out_k     = k_q;
    assign out_last  = (state_q == S_EMIT) && (k_q == K_LAST);
    assign busy      = (state_q != S_LOAD);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_da_dct_stage.sv
// Directed bench for da_dct_stage with a popcount partial-sum ROM; expected coefficients are hand-computed per frame.
module tb_da_dct_stage;
    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [14:0] in_data;
    logic               mode;
    logic [7:0]         rom_slice;
    logic [2:0]         rom_k;
    logic signed [14:0] rom_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [29:0] out_data;
    logic [2:0]         out_k;
    logic               out_last;
    logic               busy;
    logic [2:0]         dbg_state;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    da_dct_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .rom_slice (rom_slice),
        .rom_k     (rom_k),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_k     (out_k),
        .out_last  (out_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // partial-sum ROM: popcount of the slice, so each coefficient equals sum of x[m]
    always_comb rom_data = 15'($countones(rom_slice));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [14:0] sample(input int kind, input int i);
        if (kind == 0) return 15'(i);
        return (i < 8) ? -15'sd16384 : 15'sd16383;
    endfunction

    // driver: one frame of 16 samples, optional in_valid gaps; returns edge of last acceptance
    task automatic load_frame(input logic md, input int kind, input bit gaps, output int t_last);
        int g;
        t_last = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = sample(kind, i);
            mode     = (i == 0) ? md : ~md;
            g = 0;
            while (!in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                check_eq("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            t_last = cyc;
        end
        in_valid = 1'b0;
        in_data  = 15'sd0;
    endtask

    // receives all coefficients of a frame; scoreboard compares against exp_q
    task automatic run_frame(input logic md, input int kind, input bit gaps,
                             input longint exp_v, input int stall_k);
        logic [29:0] exp_q[$];
        int t_last;
        int hs;
        int g;
        for (int k = 0; k < 8; k++) exp_q.push_back(30'(exp_v));
        out_ready = (stall_k == 0) ? 1'b0 : 1'b1;
        load_frame(md, kind, gaps, t_last);
        hs = 0;
        for (int k = 0; k < 8; k++) begin
            logic signed [29:0] e;
            e = exp_q.pop_front();
            g = 0;
            while (!out_valid && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (g >= 200) begin
                check_eq("out_valid_timeout", 0, 1);
                out_ready = 1'b1;
                return;
            end
            if (k == 0) check_eq("latency_first", cyc - t_last, 18);
            else        check_eq("latency_next", cyc - hs, 17);
            check_eq("out_data", out_data, e);
            check_eq("out_k", out_k, k);
            check_eq("out_last", out_last, (k == 7) ? 1 : 0);
            check_eq("busy_emit", busy, 1);
            if (k == stall_k) begin
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    check_eq("stall_valid", out_valid, 1);
                    check_eq("stall_data", out_data, e);
                    check_eq("stall_k", out_k, k);
                    check_eq("stall_rom_k", rom_k, 0);
                end
                out_ready = 1'b1;
            end
            hs = cyc + 1;
            @(negedge clk);
            if (k + 1 == stall_k) out_ready = 1'b0;
        end
        check_eq("in_ready_after_last", in_ready, 1);
        check_eq("busy_after_last", busy, 0);
    endtask

    initial begin
        int t_last;
        int g;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 15'sd0;
        mode = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rom_slice", rom_slice, 0);
        rst = 1'b1;
        check_eq("rel_in_ready_pre", in_ready, 0);
        @(negedge clk);
        check_eq("rel_in_ready_post", in_ready, 1);

        // odd half of a ramp: x = 2m-15, sum -64
        run_frame(1'b0, 0, 1'b0, -64, -1);
        // even half of a ramp, back-to-back, with input gaps: x = 15, sum 120
        run_frame(1'b1, 0, 1'b1, 120, -1);
        // full-scale difference exercising the negative MSB slice
        run_frame(1'b0, 1, 1'b0, -262136, -1);
        // backpressure on k = 3
        run_frame(1'b0, 0, 1'b0, -64, 3);

        // reset during accumulation of k = 2
        out_ready = 1'b1;
        load_frame(1'b0, 0, 1'b0, t_last);
        for (int k = 0; k < 2; k++) begin
            g = 0;
            while (!out_valid && g < 200) begin
                @(negedge clk);
                g++;
            end
            check_eq("pre_rst_k", out_k, k);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_eq("pre_rst_rom_k", rom_k, 2);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_data", out_data, 0);
        check_eq("mid_rst_out_k", out_k, 0);
        check_eq("mid_rst_rom_k", rom_k, 0);
        check_eq("mid_rst_rom_slice", rom_slice, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        check_eq("mid_rel_in_ready_pre", in_ready, 0);
        @(negedge clk);
        check_eq("mid_rel_in_ready_post", in_ready, 1);
        g = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) g++;
        end
        check_eq("no_stale_valid", g, 0);
        run_frame(1'b0, 0, 1'b0, -64, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/da_dct_stage.md
# da_dct_stage

Parametrised distributed-arithmetic (DA) DCT half-stage: serially loads an NPTS-sample frame, forms the butterfly, and computes NCOEF inner products bit-serially against an external partial-sum ROM. Adds over the previous generation: selectable even (sum) or odd (difference) half, a valid/ready input, output backpressure, an explicit last-coefficient flag, and correct two's-complement DA sign handling. Sits between the sample buffer and the transpose/second-pass stage of the DCT datapath.

## Interface
- NPTS, 16, frame length; even, ≥4; H = NPTS/2
- DW, 15, signed input sample width; butterfly width BW = DW+1
- CW, 15, signed ROM word width; output width OW = CW+BW
- NCOEF, 8, coefficients per frame, 1..H; KW = max(1, clog2(NCOEF))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  DW  signed sample
- mode  in  1  0 = odd half (d[m]-d[NPTS-1-m]), 1 = even half (sum); sampled with first sample of frame
- rom_slice  out  H  bit-slice address {x0[b],…,x[H-1][b]}, x0 is MSB
- rom_k  out  KW  coefficient index
- rom_data  in  CW  signed ROM partial sum, combinational, sampled same cycle
- out_valid  out  1  coefficient valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  OW  signed coefficient
- out_k  out  KW  index of out_data
- out_last  out  1  high with final coefficient (k = NCOEF-1)
- busy  out  1  high in any state except LOAD

## Operation
- States: LOAD → BFLY → ACC → EMIT → (ACC for next k | LOAD after last k).
- LOAD: in_ready = 1; each handshake writes buf[i], i++. Sample 0 also latches mode. After sample NPTS-1 → BFLY. in_data ignored when in_ready = 0.
- BFLY (1 cycle): x[m] = buf[m] ± buf[NPTS-1-m], m = 0..H-1, BW-bit two's complement, sign-extended operands; acc cleared, b = 0, k = 0.
- ACC (BW cycles, b = 0..BW-1): rom_slice = bit b of each x, rom_k = k. b < BW-1: acc += sext(rom_data) << b; b = BW-1: acc -= sext(rom_data) << (BW-1). acc is OW bits; no overflow by construction.
- EMIT: out_valid = 1, out_data/out_k/out_last held stable until out_ready. On handshake: k < NCOEF-1 → k++, acc cleared, b = 0, ACC; else → LOAD.
- rom_slice/rom_k only meaningful in ACC; outside ACC driven 0.
- mode and in_valid changes outside LOAD have no effect.

## Timing
- Reset (rst low, async): state LOAD, i = b = k = 0, acc = 0; in_ready = 0, out_valid = 0, out_data = 0, out_k = 0, out_last = 0, busy = 0, rom_slice = 0, rom_k = 0. in_ready rises the first clk edge after rst deasserts.
- Reset mid-frame or mid-EMIT: partial frame and pending coefficient discarded, no out_valid afterward until a full new frame is loaded.
- Load: NPTS handshake cycles minimum; gaps in in_valid stall LOAD.
- Last sample accepted at edge T: BFLY cycle T..T+1, ACC T+1..T+1+BW, out_valid high from edge T+BW+2.
- Per further coefficient: BW+1 cycles after previous handshake (zero stall).
- out_ready low in EMIT: no state advance, outputs frozen.
- in_ready returns high the edge after the final out handshake; back-to-back frames permitted.

## Configuration
- DA_DCT_SCALE_EN defined: out_data = (acc + 2^(CW-2)) >>> (CW-1), round-half-up, sign-extended to OW; removes ROM Q(CW-1) scaling.
- Undefined: out_data = raw acc. All other behaviour and timing identical.

## Test plan
- Defaults, ROM model rom_data = popcount(rom_slice), mode 0, d[m] = m → eight outputs of -64, out_k 0..7, out_last only on k = 7.
- Same ROM, mode 1, d[m] = m → eight outputs of 120.
- mode 0, d[0..7] = -16384, d[8..15] = +16383 → x = -32767, outputs -262136 (MSB-slice subtraction check).
- Latency: last sample at edge T → out_valid first high at T+18; next out_valid 17 cycles after each handshake with out_ready tied high.
- out_ready low 10 cycles at k = 3 → out_data/out_k stable, no rom_k advance; resumes with k = 4.
- rst pulsed low during ACC of k = 2 → all outputs 0 immediately; in_ready high one edge after release; fresh frame yields correct -64 set.
